// File: rtl/riscv_pkg.sv
// Core-wide widths shared by the memory subsystem.
package riscv_pkg;
  localparam int unsigned addr_p       = 8;
  localparam int unsigned data_width_p = 32;
endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous memory between the IF and DM requesters.
// Conflicts alternate round-robin; read data returns one cycle after grant, tagged by port.
module mem_arbiter
  import riscv_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    if_req_i,
  input  logic [addr_p-1:0]       if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [data_width_p-1:0] if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [addr_p-1:0]       dm_addr_i,
  input  logic [data_width_p-1:0] dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [data_width_p-1:0] dm_rdata_o,
  output logic [addr_p-1:0]       mem_addr_o,
  output logic                    mem_wr_en_o,
  output logic                    mem_rd_en_o,
  output logic [data_width_p-1:0] mem_data_o,
  input  logic [data_width_p-1:0] mem_rdata_i,
  output logic [15:0]             conflict_cnt_o
);

  logic        both_req;
  logic        if_gnt, dm_gnt, dm_store;
  logic        last_gnt_q, last_gnt_d;
  logic        if_pend_q, dm_pend_q;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  assign both_req = if_req_i & dm_req_i;

  always_comb begin
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    last_gnt_d = last_gnt_q;
    if (rstn_i) begin
      if (both_req) begin
        // last_gnt_q: 0 = IF, 1 = DM; a conflict goes to the other port.
        if_gnt     = last_gnt_q;
        dm_gnt     = ~last_gnt_q;
        last_gnt_d = ~last_gnt_q;
      end else begin
        if_gnt = if_req_i;
        dm_gnt = dm_req_i;
      end
    end
  end

  assign dm_store = dm_gnt & dm_we_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    if (if_gnt) begin
      mem_addr_o  = if_addr_i;
      mem_rd_en_o = 1'b1;
    end else if (dm_gnt) begin
      mem_addr_o  = dm_addr_i;
      mem_rd_en_o = ~dm_we_i;
      mem_wr_en_o = dm_we_i;
      mem_data_o  = dm_store ? dm_wdata_i : '0;
    end
  end

  assign conflict_cnt_d = (both_req && (conflict_cnt_q != 16'hFFFF)) ?
                          conflict_cnt_q + 16'd1 : conflict_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt_q     <= 1'b0;
      if_pend_q      <= 1'b0;
      dm_pend_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      last_gnt_q     <= last_gnt_d;
      if_pend_q      <= if_gnt;
      dm_pend_q      <= dm_gnt & ~dm_we_i;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign if_gnt_o       = if_gnt;
  assign dm_gnt_o       = dm_gnt;
  assign if_rvalid_o    = if_pend_q;
  assign dm_rvalid_o    = dm_pend_q;
  assign if_rdata_o     = if_pend_q ? mem_rdata_i : '0;
  assign dm_rdata_o     = dm_pend_q ? mem_rdata_i : '0;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
